// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit owning the
// architectural HI/LO registers.
//   CLK, RST       clock, synchronous active-low reset
//   Start, Op      begin MULT(00)/MULTU(01)/DIV(10)/DIVU(11) when idle
//   OpA, OpB       rs/rt operands, latched on Start
//   MTHI, MTLO     write WrData into HI/LO when idle
//   Cancel         abort an operation in flight, HI/LO untouched
//   HI, LO         architectural result registers
//   Busy           operation in flight
//   Done           one-cycle pulse after HI/LO take a result
// Operations take ITER (=32) cycles; all outputs are registered.
module mult_div_unit #(
    parameter int unsigned ITER = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] WrData,
    input  logic        Cancel,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST = 6'(ITER - 1);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;    // product/quotient must be negated
    logic        neg_rem_q;    // remainder takes dividend's sign
    logic        div0_q;
    logic [31:0] raw_a_q;      // unmodified OpA, returned in HI on divide by zero
    logic [31:0] opb_q;        // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_hi_q;     // partial product upper half / remainder
    logic [31:0] acc_lo_q;     // multiplier shift register / dividend-quotient
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    // Operand magnitudes at Start; Op[0]=0 selects the signed variants.
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        a_neg = ~Op[0] & OpA[31];
        b_neg = ~Op[0] & OpB[31];
        mag_a = a_neg ? (~OpA + 32'd1) : OpA;
        mag_b = b_neg ? (~OpB + 32'd1) : OpB;
    end

    // One iteration step for either operation.
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [31:0] iter_hi_d, iter_lo_d;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi_d, res_lo_d;

    always_comb begin
        // Shift-add: conditionally add multiplicand, then shift {hi,lo} right.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
        // Restoring: shift next dividend bit into remainder, try subtracting.
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            iter_hi_d = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            iter_lo_d = {acc_lo_q[30:0], ~div_diff[32]};
        end else begin
            iter_hi_d = mul_sum[32:1];
            iter_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end

        prod     = {iter_hi_d, iter_lo_d};
        prod_fix = neg_res_q ? (~prod + 64'd1) : prod;
        quo_fix  = neg_res_q ? (~iter_lo_d + 32'd1) : iter_lo_d;
        rem_fix  = neg_rem_q ? (~iter_hi_d + 32'd1) : iter_hi_d;

        if (!is_div_q) begin
            res_hi_d = prod_fix[63:32];
            res_lo_d = prod_fix[31:0];
        end else if (div0_q) begin
            res_hi_d = raw_a_q;
            res_lo_d = '1;
        end else begin
            res_hi_d = rem_fix;
            res_lo_d = quo_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            raw_a_q   <= '0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= Op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= (OpB == 32'd0);
                        raw_a_q   <= OpA;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= Op[1] ? mag_a : mag_b;
                        opb_q     <= Op[1] ? mag_b : mag_a;
                    end else begin
                        if (MTHI) hi_q <= WrData;
                        if (MTLO) lo_q <= WrData;
                    end
                end
                RUN: begin
                    if (Cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_hi_q <= iter_hi_d;
                        acc_lo_q <= iter_lo_d;
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == LAST) begin
                            hi_q    <= res_hi_d;
                            lo_q    <= res_lo_d;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
